mul2_seq_ctrl: RTL
==================

Name: mul2_seq_ctrl

Overview:
Sequencer that time-shares one 2x2-bit multiplier (mul_2bit) to form a full WIDTH x WIDTH unsigned product for FIR tap arithmetic.
- Steps through every 2-bit digit pair of the operands, one pair per clock.
- Accumulates each 4-bit partial product shifted by 2*(i+j).
- Uses valid/ready handshakes on input and output, so FIR tap control can stall it or be stalled by it.
- Trades throughput for area: exactly one mul_2bit instance regardless of WIDTH.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; DIGITS = WIDTH/2, PAIRS = DIGITS*DIGITS.

Ports:
clk  input  1  clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  unsigned a*b, registered
busy  output  1  high in RUN or DONE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator=0, digit indices i=j=0.
- Reset mid-operation (RUN or DONE):
  - Aborts the operation and discards the product.
  - The next edge yields the reset values above.
- States are IDLE, RUN and DONE (encoding in package).
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b, clear the accumulator, set i=j=0, go to RUN.
- RUN:
  - in_ready=0; in_valid and a/b are ignored.
  - Each cycle, drive mul_2bit with p1:p0 = a_reg[2i+1:2i] and q1:q0 = b_reg[2j+1:2j].
  - At the edge: acc <= acc + (r << 2*(i+j)). The addition is 2*WIDTH bits wide; overflow cannot occur for unsigned operands.
  - Index order: j increments each cycle; when j = DIGITS-1, j wraps to 0 and i increments.
  - On the edge that accumulates pair (DIGITS-1, DIGITS-1): the final sum is written directly into product, state goes to DONE.
- DONE:
  - out_valid=1; product held stable.
  - On an edge with out_ready=1: out_valid goes to 0, state goes to IDLE.
  - product keeps its last value until the next completion or reset.
- Latency: out_valid rises PAIRS edges after the accepting edge (16 for WIDTH=8, 1 for WIDTH=2).
  - Initiation interval is PAIRS+2 cycles with out_ready held high: accept, PAIRS RUN cycles, one DONE cycle, then IDLE.
- No bypass paths:
  - in_ready is never asserted in the same cycle as out_valid.
  - A new operation begins only from IDLE.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Zero operands are not short-circuited; timing is data-independent.

Decomposition:
- Shared package mul2_seq_pkg:
  - state encoding constants IDLE/RUN/DONE;
  - helpers for DIGITS, PAIRS and the index counter width, clog2(DIGITS) with minimum 1.
- The only sub-module is one instance of the existing mul_2bit, driven combinationally from the digit muxes.
- Controller FSM, index counters, operand registers and accumulator stay in mul2_seq_ctrl.

Test Plan:
1. WIDTH=8, a=0xFF, b=0xFF, out_ready=1 -> out_valid exactly 16 edges after accept, product=0xFE01, then in_ready=1 on the following cycle.
2. a=0xA5, b=0x3C -> product=0x26AC. Repeat with a=0x00, b=0xB7 -> product=0x0000, same 16-cycle latency.
3. Backpressure: complete a=0x12, b=0x34 (product=0x03A8), hold out_ready=0 for 20 cycles -> out_valid stays 1, product stable at 0x03A8, in_ready=0. Then out_ready=1 -> out_valid=0 next edge.
4. Assert in_valid with a=0x01, b=0x01 during RUN -> ignored; the original product is unchanged and no second result appears.
5. rst=1 for one edge at RUN cycle 7 -> next cycle in_ready=1, out_valid=0, busy=0, product=0. A fresh a=0x03, b=0x05 then gives 0x000F.
6. WIDTH=2 build, a=2'b11, b=2'b11 -> out_valid 1 edge after accept, product=4'b1001. Also sweep all 16 operand pairs against a reference model.

Source files
------------

// File: rtl/mul2_seq_pkg.sv
// Shared types and sizing helpers for the digit-serial 2x2 multiplier sequencer.
package mul2_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int digits(input int w);
    return w / 2;
  endfunction

  function automatic int pairs(input int w);
    return (w / 2) * (w / 2);
  endfunction

  // Digit index width; a single-digit operand still needs a 1-bit counter.
  function automatic int idx_w(input int w);
    return ($clog2(w / 2) < 1) ? 1 : $clog2(w / 2);
  endfunction

endpackage

// File: rtl/mul_2bit.sv
// 2-bit x 2-bit unsigned multiplier, purely combinational.
module mul_2bit (
  input  logic       p1,
  input  logic       p0,
  input  logic       q1,
  input  logic       q0,
  output logic [3:0] r
);

  assign r = 4'({p1, p0}) * 4'({q1, q0});

endmodule

// File: rtl/mul2_seq_ctrl.sv
// Forms a WIDTH x WIDTH unsigned product by stepping one mul_2bit through every
// digit pair, one pair per clock, with valid/ready on both sides.
module mul2_seq_ctrl
  import mul2_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int DIGITS = digits(WIDTH);
  localparam int IW     = idx_w(WIDTH);
  localparam int PW     = 2 * WIDTH;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [PW-1:0]    acc, acc_nxt, pp;
  logic [IW-1:0]    i, j;
  logic [IW:0]      ij;
  logic [1:0]       pd, qd;
  logic [3:0]       r;
  logic             j_last, last_pair;

  // Digit muxes feed the shared multiplier directly; no pipeline stage here.
  always_comb begin
    pd        = 2'(a_reg >> {i, 1'b0});
    qd        = 2'(b_reg >> {j, 1'b0});
    ij        = {1'b0, i} + {1'b0, j};
    pp        = PW'(r) << {ij, 1'b0};
    acc_nxt   = acc + pp;
    j_last    = (j == IW'(DIGITS - 1));
    last_pair = j_last && (i == IW'(DIGITS - 1));
  end

  mul_2bit u_mul (
    .p1 (pd[1]),
    .p0 (pd[0]),
    .q1 (qd[1]),
    .q0 (qd[0]),
    .r  (r)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_pair) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      i       <= '0;
      j       <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a;
          b_reg <= b;
          acc   <= '0;
          i     <= '0;
          j     <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          if (last_pair) begin
            product <= acc_nxt;
            i       <= '0;
            j       <= '0;
          end else if (j_last) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
